uart_rx_core: RTL
=================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLK_HZ, 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, line bit rate.
REQ-003 Port CLK  in  1  sole clock; all logic on rising edge.
REQ-004 Port RST  in  1  reset, synchronous, active-high.
REQ-005 Port RXD  in  1  asynchronous serial line, 8 data bits, LSB first, idle high.
REQ-006 Port DATA  out  8  received byte; valid while VALID=1.
REQ-007 Port VALID  out  1  byte available.
REQ-008 Port READY  in  1  consumer accepts the byte; transfer occurs on VALID&READY.
REQ-009 Port FRAME_ERR  out  1  one-cycle pulse on a bad stop bit.
REQ-010 Port OVERRUN  out  1  one-cycle pulse when a completed byte is dropped.
REQ-011 Port PARITY_ERR  out  1  one-cycle pulse on an even-parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-012 RXD SHALL pass a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value.
REQ-013 The oversample tick SHALL fire once every DIV=CLK_HZ/(BAUD*16) clocks (integer, DIV>=1); the divider SHALL restart at 0 on entering START.
REQ-014 The FSM SHALL use the states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-015 IDLE->START SHALL occur on the first cycle with synchronized RXD=0.
REQ-016 START SHALL sample at tick 8; RXD=1 -> IDLE (glitch rejected, no error); RXD=0 -> DATA.
REQ-017 DATA SHALL sample each bit at 16-tick intervals after the start-bit sample, shift LSB first, and count 8 bits with a 3-bit counter.
REQ-018 After bit 7, the FSM SHALL go to PARITY if UART_RX_PARITY_EN is defined, else to STOP.
REQ-019 STOP SHALL sample 16 ticks after the last data or parity sample. RXD=1: byte complete, go to IDLE. RXD=0: FRAME_ERR pulse, byte discarded, go to WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL remain until synchronized RXD=1, then go to IDLE.
REQ-021 On byte complete, DATA/VALID SHALL update on the clock after the stop sample (latency 1 cycle).
REQ-022 Once VALID=1, it and DATA SHALL hold stable until a cycle with READY=1; VALID clears on the following edge.
REQ-023 If a byte completes while VALID=1 and READY=0, the new byte SHALL be dropped, the old byte and VALID kept, and OVERRUN pulsed.
REQ-024 If a byte completes in the same cycle as VALID&READY, the new byte SHALL be loaded, VALID stays 1, and no OVERRUN is raised.
REQ-025 A break (RXD held low) SHALL yield exactly one FRAME_ERR pulse, then WAIT_IDLE until RXD returns high.

Reset
REQ-026 RST=1 SHALL force state IDLE, divider/bit counters 0, shift register 0, DATA=0, VALID=0, and all error pulses 0.
REQ-027 RST asserted mid-frame SHALL abandon the frame with no VALID or error output; reception resumes at the next falling edge after release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: the PARITY state samples a 9th bit; XOR of the 8 data bits and the parity bit =1 -> PARITY_ERR pulse with the byte discarded (STOP still sampled); PARITY_ERR port exists.
REQ-029 Macro undefined: no PARITY state, no PARITY_ERR port, 10-bit frame.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum, OVERSAMPLE=16, MID_SAMPLE=8 and DATA_BITS=8.
REQ-031 The divider SHALL be the sub-module uart_baud_tick (inputs CLK, RST, restart; output tick).

Verification (CLK_HZ=3200000, BAUD=100000, DIV=2, 32 clk/bit)
REQ-032 Frame 0xA5, READY=1 -> VALID=1 for 1 cycle, DATA=0xA5, 1 cycle after the stop sample; no errors.
REQ-033 16-clock low glitch on RXD -> no VALID, no FRAME_ERR, FSM back to IDLE.
REQ-034 Frame 0x3C with stop bit 0 -> one FRAME_ERR pulse, VALID stays 0; next frame 0x11 is received correctly.
REQ-035 Bytes 0x01 then 0x02 with READY=0 -> VALID held with DATA=0x01, OVERRUN pulses once; READY=1 then returns 0x01.
REQ-036 With parity enabled, 0x07 sent with parity 0 -> PARITY_ERR pulse, no VALID; with parity 1 -> VALID, DATA=0x07.
REQ-037 RST pulse at data bit 4 of a frame -> no VALID; the following frame 0xFF is received correctly.

Source files
------------

// File: rtl/uart_rx_core_pkg.sv
// Shared constants and FSM state encodings for the UART receiver.
// Optional even-parity support is selected with UART_RX_PARITY_EN.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_START     = 3'd1;
    localparam state_t S_DATA      = 3'd2;
    localparam state_t S_PARITY    = 3'd3;
    localparam state_t S_STOP      = 3'd4;
    localparam state_t S_WAIT_IDLE = 3'd5;
endpackage

// File: rtl/uart_rx_core_if.sv
// Valid/ready byte stream leaving the UART receiver.
// master drives DATA/VALID, slave drives READY.
interface uart_rx_core_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] DATA;
    logic                 VALID;
    logic                 READY;

    modport master (
        output DATA,
        output VALID,
        input  READY
    );

    modport slave (
        input  DATA,
        input  VALID,
        output READY
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks.
// restart holds the count at zero so the next tick is a full period away.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last;

    assign last = (cnt_q == CW'(DIV - 1));
    assign tick = last && !restart;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || last)
            cnt_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receiver, 8N1 with valid/ready output.
// Define UART_RX_PARITY_EN for an even-parity bit and PARITY_ERR.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic CLK,
    input  logic RST,
    input  logic RXD,
    uart_rx_core_if.master rx,
    output logic FRAME_ERR,
    output logic OVERRUN
`ifdef UART_RX_PARITY_EN
    ,
    output logic PARITY_ERR
`endif
);
    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rxd_s;
    state_t               state_q,    state_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] data_q,     data_d;
    logic                 valid_q,    valid_d;
    logic                 ferr_q,     ferr_d;
    logic                 ovr_q,      ovr_d;
`ifdef UART_RX_PARITY_EN
    logic                 pbad_q,     pbad_d;
    logic                 perr_q,     perr_d;
`endif
    logic                 tick;
    logic                 restart;
    logic                 mid_pt;
    logic                 bit_pt;
    logic                 done;

    assign rxd_s   = sync2_q;
    assign restart = (state_q == S_IDLE);
    assign mid_pt  = tick && (tick_cnt_q == 4'(MID_SAMPLE - 1));
    assign bit_pt  = tick && (tick_cnt_q == 4'(OVERSAMPLE - 1));

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .CLK    (CLK),
        .RST    (RST),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        done       = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d     = pbad_q;
        perr_d     = 1'b0;
`endif
        if (tick)
            tick_cnt_d = tick_cnt_q + 4'd1;

        unique case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                pbad_d     = 1'b0;
`endif
                if (!rxd_s)
                    state_d = S_START;
            end
            S_START: begin
                // realign so later samples land 16 ticks apart
                if (mid_pt) begin
                    tick_cnt_d = '0;
                    state_d    = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_pt) begin
                    shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_pt) begin
                    pbad_d  = ^{shift_q, rxd_s};
                    perr_d  = ^{shift_q, rxd_s};
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_pt) begin
                    if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                        done = !pbad_q;
`else
                        done = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rxd_s)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done) begin
            if (valid_q && !rx.READY) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && rx.READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q     <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            sync1_q    <= RXD;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
            pbad_q     <= pbad_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign rx.DATA   = data_q;
    assign rx.VALID  = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = perr_q;
`endif
endmodule
